// File: rtl/plic_multi_target.sv
// rtl/plic_multi_target.sv - multi-target PLIC register block with per-source gateways
// Level/edge gateways with edge-count buffering, per-target arbitration and claim/complete.
module plic_multi_target #(
    parameter int          SRC_NUM    = 31,
    parameter int          TGT_NUM    = 2,
    parameter int          PRIO_WIDTH = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h9000_0000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               if_reg_en,
    input  logic               if_reg_wr,
    input  logic [31:0]        if_reg_addr,
    input  logic [63:0]        if_reg_wdata,
    output logic [63:0]        reg_if_rdata,
    input  logic [SRC_NUM:0]   irq_src,
    output logic [TGT_NUM-1:0] irq_o,
    output logic [7:0]         claim_id_o
);

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PEND    = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_t;

    logic [31:0]           off;
    logic                  acc_wr;
    logic                  acc_rd;

    logic [PRIO_WIDTH-1:0] prio      [1:SRC_NUM];
    logic [SRC_NUM:1]      enable    [TGT_NUM];
    logic [PRIO_WIDTH-1:0] threshold [TGT_NUM];
    logic [SRC_NUM:1]      trig_mode;
    logic [SRC_NUM:1]      src_q;

    gw_state_t             gw_q      [1:SRC_NUM];
    gw_state_t             gw_d      [1:SRC_NUM];
    logic [1:0]            ecnt_q    [1:SRC_NUM];
    logic [1:0]            ecnt_d    [1:SRC_NUM];

    logic [SRC_NUM:1]      pend_vec;
    logic [SRC_NUM:1]      rise_vec;
    logic [SRC_NUM:1]      claim_vec;
    logic [SRC_NUM:1]      cmp_vec;
    logic [SRC_NUM:1]      trig_clr;
    logic [TGT_NUM-1:0]    claim_hit;
    logic [TGT_NUM-1:0]    cmp_hit;
    logic [7:0]            winner    [TGT_NUM];
    logic [PRIO_WIDTH-1:0] best_prio [TGT_NUM];

    logic                  unused_bits;

    assign off      = if_reg_addr - BASE_ADDR;
    assign acc_wr   = if_reg_en & if_reg_wr;
    assign acc_rd   = if_reg_en & ~if_reg_wr;
    assign rise_vec = irq_src[SRC_NUM:1] & ~src_q;
    assign trig_clr = (acc_wr && off == 32'h0000_1004) ? ~if_reg_wdata[SRC_NUM:1] : '0;
    assign unused_bits = ^{irq_src[0], if_reg_wdata[63:32]};

    always_comb begin
        for (int i = 1; i <= SRC_NUM; i++) begin
            pend_vec[i] = (gw_q[i] == GW_PEND);
        end
    end

    // claim and complete share one address per target; direction selects the action
    always_comb begin
        claim_hit = '0;
        cmp_hit   = '0;
        for (int t = 0; t < TGT_NUM; t++) begin
            claim_hit[t] = acc_rd && (off == 32'h0020_0004 + 32'(t) * 32'h1000);
            cmp_hit[t]   = acc_wr && (off == 32'h0020_0004 + 32'(t) * 32'h1000);
        end
    end

    // strict greater-than while scanning upward keeps the lowest id on ties
    always_comb begin
        for (int t = 0; t < TGT_NUM; t++) begin
            best_prio[t] = '0;
            winner[t]    = '0;
            for (int i = 1; i <= SRC_NUM; i++) begin
                if (pend_vec[i] && enable[t][i] && prio[i] > threshold[t]
                    && prio[i] > best_prio[t]) begin
                    best_prio[t] = prio[i];
                    winner[t]    = 8'(i);
                end
            end
        end
    end

    always_comb begin
        claim_vec = '0;
        cmp_vec   = '0;
        for (int i = 1; i <= SRC_NUM; i++) begin
            for (int t = 0; t < TGT_NUM; t++) begin
                if (claim_hit[t] && winner[t] == 8'(i)) begin
                    claim_vec[i] = 1'b1;
                end
                if (cmp_hit[t] && if_reg_wdata[7:0] == 8'(i) && enable[t][i]) begin
                    cmp_vec[i] = 1'b1;
                end
            end
        end
    end

    // a same-cycle edge is counted before the complete rule looks at ecnt
    always_comb begin
        for (int i = 1; i <= SRC_NUM; i++) begin
            gw_d[i]   = gw_q[i];
            ecnt_d[i] = ecnt_q[i];
            if (gw_q[i] != GW_IDLE && trig_mode[i] && rise_vec[i] && ecnt_q[i] != 2'd3) begin
                ecnt_d[i] = ecnt_q[i] + 2'd1;
            end
            case (gw_q[i])
                GW_IDLE: begin
                    if (trig_mode[i] ? rise_vec[i] : irq_src[i]) begin
                        gw_d[i] = GW_PEND;
                    end
                end
                GW_PEND: begin
                    if (claim_vec[i]) begin
                        gw_d[i] = GW_CLAIMED;
                    end
                end
                GW_CLAIMED: begin
                    if (cmp_vec[i]) begin
                        if (trig_mode[i] && ecnt_d[i] != 2'd0) begin
                            ecnt_d[i] = ecnt_d[i] - 2'd1;
                            gw_d[i]   = GW_PEND;
                        end else begin
                            gw_d[i] = GW_IDLE;
                        end
                    end
                end
                default: gw_d[i] = GW_IDLE;
            endcase
            if (trig_clr[i]) begin
                ecnt_d[i] = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i <= SRC_NUM; i++) begin
                gw_q[i]   <= GW_IDLE;
                ecnt_q[i] <= 2'd0;
            end
            src_q <= '0;
        end else begin
            for (int i = 1; i <= SRC_NUM; i++) begin
                gw_q[i]   <= gw_d[i];
                ecnt_q[i] <= ecnt_d[i];
            end
            src_q <= irq_src[SRC_NUM:1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i <= SRC_NUM; i++) begin
                prio[i] <= '0;
            end
            for (int t = 0; t < TGT_NUM; t++) begin
                enable[t]    <= '0;
                threshold[t] <= '0;
            end
            trig_mode <= '0;
        end else if (acc_wr) begin
            for (int i = 1; i <= SRC_NUM; i++) begin
                if (off == 32'(4 * i)) begin
                    prio[i] <= if_reg_wdata[PRIO_WIDTH-1:0];
                end
            end
            for (int t = 0; t < TGT_NUM; t++) begin
                if (off == 32'h0000_2000 + 32'(t) * 32'h80) begin
                    enable[t] <= if_reg_wdata[SRC_NUM:1];
                end
                if (off == 32'h0020_0000 + 32'(t) * 32'h1000) begin
                    threshold[t] <= if_reg_wdata[PRIO_WIDTH-1:0];
                end
            end
            if (off == 32'h0000_1004) begin
                trig_mode <= if_reg_wdata[SRC_NUM:1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_o      <= '0;
            claim_id_o <= '0;
        end else begin
            for (int t = 0; t < TGT_NUM; t++) begin
                irq_o[t] <= (winner[t] != 8'd0);
                if (claim_hit[t]) begin
                    claim_id_o <= winner[t];
                end
            end
        end
    end

    always_comb begin
        reg_if_rdata = '0;
        if (acc_rd) begin
            for (int i = 1; i <= SRC_NUM; i++) begin
                if (off == 32'(4 * i)) begin
                    reg_if_rdata = 64'(prio[i]);
                end
            end
            if (off == 32'h0000_1000) begin
                reg_if_rdata = 64'({pend_vec, 1'b0});
            end
            if (off == 32'h0000_1004) begin
                reg_if_rdata = 64'({trig_mode, 1'b0});
            end
            for (int t = 0; t < TGT_NUM; t++) begin
                if (off == 32'h0000_2000 + 32'(t) * 32'h80) begin
                    reg_if_rdata = 64'({enable[t], 1'b0});
                end
                if (off == 32'h0020_0000 + 32'(t) * 32'h1000) begin
                    reg_if_rdata = 64'(threshold[t]);
                end
                if (claim_hit[t]) begin
                    reg_if_rdata = 64'(winner[t]);
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_multi_target.sv
// tb/tb_plic_multi_target.sv - scoreboard bench for plic_multi_target
module tb_plic_multi_target;

    localparam logic [31:0] BASE  = 32'h9000_0000;
    localparam logic [31:0] PENDR = 32'h0000_1000;
    localparam logic [31:0] TRIG  = 32'h0000_1004;
    localparam logic [31:0] EN0   = 32'h0000_2000;
    localparam logic [31:0] EN1   = 32'h0000_2080;
    localparam logic [31:0] TH0   = 32'h0020_0000;
    localparam logic [31:0] TH1   = 32'h0020_1000;
    localparam logic [31:0] CLM0  = 32'h0020_0004;
    localparam logic [31:0] CLM1  = 32'h0020_1004;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [31:0] src;
    logic [1:0]  irq;
    logic [7:0]  cid;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];

    plic_multi_target #(
        .SRC_NUM(31), .TGT_NUM(2), .PRIO_WIDTH(3), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rstn(rstn), .if_reg_en(en), .if_reg_wr(wr),
        .if_reg_addr(addr), .if_reg_wdata(wdata), .reg_if_rdata(rdata),
        .irq_src(src), .irq_o(irq), .claim_id_o(cid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic sb_expect(input string tag, input logic [63:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic sb_compare(input logic [63:0] got);
        logic [63:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, got, e);
    endtask

    task automatic bus_wr(input logic [31:0] o, input logic [63:0] d);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = BASE + o; wdata = d;
        @(posedge clk);
        #1;
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] o, input logic [63:0] exp);
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = BASE + o;
        sb_expect(tag, exp);
        #1;
        sb_compare(rdata);
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic expect_irq(input string tag, input logic [1:0] exp);
        sb_expect(tag, 64'(exp));
        sb_compare(64'(irq));
    endtask

    task automatic expect_cid(input string tag, input logic [7:0] exp);
        sb_expect(tag, 64'(exp));
        sb_compare(64'(cid));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input int id, input logic v);
        @(negedge clk);
        src[id] = v;
    endtask

    task automatic pulse(input int id);
        set_src(id, 1'b1);
        set_src(id, 1'b0);
    endtask

    logic [31:0] rst_offs [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_offs = '{32'h0, 32'h4, 32'hC, 32'h7C, PENDR, TRIG, EN0, EN1,
                     TH0, TH1, CLM0, CLM1, 32'h1008};
        rstn = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0; src = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // reset state
        @(negedge clk);
        expect_irq("rst_irq", 2'b00);
        expect_cid("rst_cid", 8'd0);
        for (int k = 0; k < 13; k++) bus_rd($sformatf("rst_rd_%0h", rst_offs[k]), rst_offs[k], 64'd0);
        bus_wr(PENDR, '1);
        bus_wr(32'h0, 64'd7);
        bus_rd("ro_pending", PENDR, 64'd0);
        bus_rd("prio0", 32'h0, 64'd0);

        // level source 3 on target 0
        bus_wr(32'hC, 64'd2);
        bus_wr(EN0, 64'h8);
        bus_wr(TH0, 64'd1);
        bus_rd("prio3_rb", 32'hC, 64'd2);
        set_src(3, 1'b1);
        @(posedge clk); @(negedge clk);
        expect_irq("lvl_irq_n", 2'b00);
        @(negedge clk);
        expect_irq("lvl_irq_n1", 2'b01);
        bus_rd("lvl_pending", PENDR, 64'h8);
        bus_rd("lvl_claim", CLM0, 64'd3);
        @(negedge clk);
        expect_cid("lvl_cid", 8'd3);
        expect_irq("lvl_irq_hold", 2'b01);
        @(negedge clk);
        expect_irq("lvl_irq_drop", 2'b00);
        bus_rd("lvl_pend_clr", PENDR, 64'h0);
        bus_wr(CLM0, 64'd3);
        wait_cyc(2);
        expect_irq("lvl_repend", 2'b01);
        set_src(3, 1'b0);
        bus_rd("lvl_claim2", CLM0, 64'd3);
        bus_wr(CLM0, 64'd3);

        // priority tie between 5 and 6, then threshold masking
        bus_wr(EN0, 64'h60);
        bus_wr(32'h14, 64'd4);
        bus_wr(32'h18, 64'd4);
        @(negedge clk);
        src[5] = 1'b1; src[6] = 1'b1;
        wait_cyc(2);
        bus_rd("tie_first", CLM0, 64'd5);
        bus_rd("tie_second", CLM0, 64'd6);
        @(negedge clk);
        src[5] = 1'b0; src[6] = 1'b0;
        bus_wr(CLM0, 64'd5);
        bus_wr(CLM0, 64'd6);
        bus_wr(TH0, 64'd4);
        set_src(5, 1'b1);
        wait_cyc(2);
        src[5] = 1'b0;
        expect_irq("thr_irq", 2'b00);
        bus_rd("thr_claim", CLM0, 64'd0);
        bus_rd("thr_pending", PENDR, 64'h20);

        // edge source 7 with saturating edge counter
        bus_wr(TRIG, 64'h80);
        bus_wr(32'h1C, 64'd3);
        bus_wr(EN0, 64'h80);
        bus_wr(TH0, 64'd0);
        bus_rd("trig_rb", TRIG, 64'h80);
        pulse(7);
        wait_cyc(2);
        bus_rd("edge_claim0", CLM0, 64'd7);
        for (int k = 0; k < 4; k++) pulse(7);
        for (int k = 0; k < 3; k++) begin
            bus_wr(CLM0, 64'd7);
            bus_rd($sformatf("edge_repend_%0d", k), PENDR, 64'h80 | 64'h20);
            bus_rd($sformatf("edge_claim_%0d", k + 1), CLM0, 64'd7);
        end
        bus_wr(CLM0, 64'd7);
        bus_rd("edge_idle_pend", PENDR, 64'h20);
        bus_rd("edge_idle_claim", CLM0, 64'd0);

        // two targets: source 2 routed only to target 1
        bus_wr(EN0, 64'h0);
        bus_wr(32'h8, 64'd1);
        bus_wr(EN1, 64'h4);
        set_src(2, 1'b1);
        wait_cyc(2);
        expect_irq("tgt1_irq", 2'b10);
        bus_rd("tgt1_claim", CLM1, 64'd2);
        bus_wr(CLM0, 64'd2);
        wait_cyc(2);
        bus_rd("tgt0_cmp_ignored", PENDR, 64'h20);
        expect_irq("tgt0_cmp_irq", 2'b00);
        bus_wr(CLM1, 64'd2);
        wait_cyc(2);
        bus_rd("tgt1_cmp_repend", PENDR, 64'h24);
        expect_irq("tgt1_irq_again", 2'b10);
        bus_rd("tgt1_claim2", CLM1, 64'd2);

        // illegal completes leave source 2 claimed
        bus_wr(CLM1, 64'd0);
        bus_wr(CLM1, 64'd40);
        bus_wr(CLM1, 64'd34);
        bus_wr(CLM1, 64'd3);
        wait_cyc(2);
        bus_rd("bad_cmp_pending", PENDR, 64'h20);

        // asynchronous reset mid-operation
        bus_wr(EN0, 64'h20);
        wait_cyc(2);
        expect_irq("pre_rst_irq", 2'b01);
        expect_cid("pre_rst_cid", 8'd2);
        #2;
        rstn = 1'b0;
        #1;
        expect_irq("async_rst_irq", 2'b00);
        expect_cid("async_rst_cid", 8'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        bus_rd("post_rst_pending", PENDR, 64'h4);
        bus_rd("post_rst_prio5", 32'h14, 64'd0);
        bus_rd("post_rst_en0", EN0, 64'd0);
        bus_rd("post_rst_trig", TRIG, 64'd0);
        expect_irq("post_rst_irq", 2'b00);

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/plic_multi_target.md
# plic_multi_target

Parametrised platform-level interrupt controller register block with per-source gateways and multiple interrupt targets. Sits behind the AHB-lite slave interface like the single-target interrupt register file, extending it with `TGT_NUM` targets, per-source level/edge trigger mode, edge-count buffering and a full claim/complete handshake. It drives one registered interrupt line per target to the hart(s).

## Interface
- `SRC_NUM`, 31: number of sources, ids 1..SRC_NUM; id 0 is reserved as "none". Legal range 1..31.
- `TGT_NUM`, 2: number of targets. Legal range 1..8.
- `PRIO_WIDTH`, 3: priority and threshold width.
- `BASE_ADDR`, 32'h9000_0000: base of the register map.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `if_reg_en` in 1: bus access strobe, one cycle per access.
- `if_reg_wr` in 1: 1 = write, 0 = read.
- `if_reg_addr` in 32: byte address.
- `if_reg_wdata` in 64: write data.
- `reg_if_rdata` out 64: read data, combinational. Upper bits are zero.
- `irq_src` in SRC_NUM+1: source lines, already synchronous. Bit 0 is ignored.
- `irq_o` out TGT_NUM: registered interrupt request, one bit per target.
- `claim_id_o` out 8: id returned by the last claim, for debug. Registered.

## Operation
- Address map (offsets from `BASE_ADDR`):
  - prio[i] at 0x0000+4i, RW, PRIO_WIDTH bits. prio[0] reads 0.
  - pending at 0x1000, RO, bit i = source i.
  - trig_mode at 0x1004, RW, bit i = 1 for edge, 0 for level.
  - enable[t] at 0x2000+0x80t, RW, bits 1..SRC_NUM.
  - threshold[t] at 0x20_0000+0x1000t, RW.
  - claim/complete[t] at 0x20_0004+0x1000t.
  - Unmapped addresses read 0; writes to them are ignored. Writes to RO registers are ignored.
- Gateway per source: 2-bit state IDLE, PEND, CLAIMED, plus a 2-bit saturating edge counter `ecnt`.
  - Level mode: IDLE with src=1 goes to PEND.
  - Edge mode: IDLE with a rising edge (src & ~src_q) goes to PEND.
  - Edge mode: a rising edge in PEND or CLAIMED increments `ecnt`, saturating at 3.
- pending[i] = (state == PEND).
- Arbitration per target t:
  - Candidate = PEND & enable[t][i] & prio[i] > threshold[t]. prio 0 never interrupts.
  - Winner = highest prio; ties go to the lowest id. Winner id is 0 if there is no candidate.
- Claim (read of claim[t]):
  - rdata returns winner[t].
  - The winning source goes PEND→CLAIMED on the same edge.
  - `claim_id_o` loads the returned id.
  - A claim with winner 0 changes no state.
- Complete (write to complete[t], id = wdata[7:0]):
  - Takes effect only if id is 1..SRC_NUM and the source is CLAIMED and enable[t][id]=1. Otherwise it is ignored.
  - Edge mode with ecnt>0: ecnt decrements and the source goes to PEND.
  - Otherwise the source goes to IDLE. A level source still held high re-pends on the next cycle.
- Writing trig_mode bit to 0 clears that source's ecnt. State is unchanged; the new mode applies from the next IDLE evaluation.
- `irq_o[t]` <= (winner[t] != 0).

## Timing
- Reset values: all prio, enable, threshold and trig_mode are 0; all gateways are IDLE with ecnt=0; `src_q`=0; `irq_o`=0; `claim_id_o`=0. `reg_if_rdata`=0 while if_reg_en=0.
- Source to pending: src is sampled at edge N and pending is visible after edge N. `irq_o` rises after edge N+1, giving 2-cycle latency.
- Claim at edge M: pending clears after M, and `irq_o` falls after M+1 unless another candidate exists.
- Simultaneous edge and complete on the same source in the same cycle: the increment is applied first, then the complete rule. Net effect: ecnt unchanged and the source goes to PEND. At ecnt=3 it saturates.
- Simultaneous edge and claim: the source goes to CLAIMED and ecnt increments.
- A config write takes effect on arbitration in the following cycle.
- Reset asserted mid-operation clears everything immediately (asynchronous). Edge detection restarts with src_q=0, so a source held high sees a rising edge after reset.

## Test plan
- Reset, then read every mapped register → all 0, `irq_o`=0.
- prio[3]=2, enable[0]=0x8, threshold[0]=1, level src3 high → `irq_o[0]`=1 two cycles later. Claim[0] returns 3 and `irq_o[0]` drops. Complete 3 with src3 still high → re-pend, `irq_o[0]`=1 again.
- prio[5]=prio[6]=4, both pending and enabled on t0 → claim returns 5, then 6. With threshold[0]=4 → claim returns 0 and `irq_o[0]`=0.
- Edge src7: pulse 4 times while CLAIMED → ecnt saturates at 3. Three further completes each re-pend; the fourth returns to IDLE.
- Two targets: src2 enabled only on t1 → `irq_o`=2'b10. Complete 2 on t0 is ignored (src stays CLAIMED); complete 2 on t1 releases it.
- Complete with id 0, id 40 or a non-claimed id → no state change. Assert rstn mid-CLAIMED → all state 0 asynchronously.
